// File: rtl/iob_mem_responder_pkg.sv
// Shared constants for the IOb memory responder: default parameters, legal limits
// and the ready-FSM state type.
package iob_mem_responder_pkg;

   localparam int unsigned DEF_DATA_W      = 32;
   localparam int unsigned DEF_ADDR_W      = 12;
   localparam int unsigned DEF_READ_LAT    = 1;
   localparam int unsigned DEF_WAIT_STATES = 0;

   localparam int unsigned READ_LAT_MIN    = 1;
   localparam int unsigned READ_LAT_MAX    = 4;
   localparam int unsigned WAIT_STATES_MIN = 0;
   localparam int unsigned WAIT_STATES_MAX = 15;
   localparam int unsigned WAIT_CNT_W      = 4;

   typedef enum logic {
      ST_READY = 1'b0,
      ST_WAIT  = 1'b1
   } rdy_state_t;

   function automatic int unsigned clamp_u(input int unsigned v, input int unsigned lo,
                                           input int unsigned hi);
      return (v < lo) ? lo : ((v > hi) ? hi : v);
   endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port byte-enabled synchronous RAM, one-cycle read, with clock enable.
// Array contents are never reset; only the read-data register is.
module iob_ram_sp_be #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                cke_i,
   input  logic                en_i,
   input  logic [DATA_W/8-1:0] we_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   output logic [DATA_W-1:0]   rdata_o
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (cke_i && en_i) begin
         for (int unsigned i = 0; i < DATA_W / 8; i++) begin
            if (we_i[i]) begin
               mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end
      end
   end

   // Output register only updates on reads, so it holds the last read word.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         rdata_o <= '0;
      end else if (cke_i && en_i && !(|we_i)) begin
         rdata_o <= mem[addr_i];
      end
   end

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native-bus memory subordinate: byte-strobed writes, fixed-latency reads,
// optional wait states throttling iob_ready_o.
module iob_mem_responder
   import iob_mem_responder_pkg::*;
#(
   parameter int unsigned DATA_W      = DEF_DATA_W,
   parameter int unsigned ADDR_W      = DEF_ADDR_W,
   parameter int unsigned READ_LAT    = DEF_READ_LAT,
   parameter int unsigned WAIT_STATES = DEF_WAIT_STATES
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                cke_i,
   input  logic                iob_avalid_i,
   input  logic [ADDR_W-1:0]   iob_addr_i,
   input  logic [DATA_W-1:0]   iob_wdata_i,
   input  logic [DATA_W/8-1:0] iob_wstrb_i,
   output logic [DATA_W-1:0]   iob_rdata_o,
   output logic                iob_rvalid_o,
   output logic                iob_ready_o
);

   localparam int unsigned LAT     = clamp_u(READ_LAT, READ_LAT_MIN, READ_LAT_MAX);
   localparam int unsigned WS      = clamp_u(WAIT_STATES, WAIT_STATES_MIN, WAIT_STATES_MAX);
   localparam int unsigned WORD_AW = ADDR_W - 2;
   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'((WS == 0) ? 0 : WS - 1);

   rdy_state_t            state_q, state_d;
   logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
   logic                  accept;
   logic                  rd_accept;
   logic [LAT-1:0]        vld_q;
   logic [DATA_W-1:0]     ram_rdata;
   logic                  unused_addr_lsb;

   assign unused_addr_lsb = ^iob_addr_i[1:0];

   // Ready is forced low while reset is held, independent of the state flop.
   assign iob_ready_o = rst_n_i & (state_q == ST_READY);
   assign accept      = iob_avalid_i & iob_ready_o & cke_i;
   assign rd_accept   = accept & ~(|iob_wstrb_i);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= ST_READY;
         cnt_q   <= '0;
      end else if (cke_i) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_READY: begin
            if (accept && (WS != 0)) begin
               state_d = ST_WAIT;
               cnt_d   = WAIT_LOAD;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_READY;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = ST_READY;
      endcase
   end

   iob_ram_sp_be #(
      .DATA_W (DATA_W),
      .ADDR_W (WORD_AW)
   ) u_ram (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .cke_i   (cke_i),
      .en_i    (accept),
      .we_i    (iob_wstrb_i),
      .addr_i  (iob_addr_i[ADDR_W-1:2]),
      .wdata_i (iob_wdata_i),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         vld_q <= '0;
      end else if (cke_i) begin
         vld_q[0] <= rd_accept;
         for (int unsigned i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
         end
      end
   end

   assign iob_rvalid_o = vld_q[LAT-1];

   // Each stage loads only behind a valid token so the output keeps the last read word.
   if (LAT == 1) begin : g_lat1
      assign iob_rdata_o = ram_rdata;
   end else begin : g_latn
      logic [DATA_W-1:0] stg_q [LAT-1];

      always_ff @(posedge clk_i) begin
         if (!rst_n_i) begin
            for (int unsigned i = 0; i < LAT - 1; i++) begin
               stg_q[i] <= '0;
            end
         end else if (cke_i) begin
            if (vld_q[0]) begin
               stg_q[0] <= ram_rdata;
            end
            for (int unsigned i = 1; i < LAT - 1; i++) begin
               if (vld_q[i]) begin
                  stg_q[i] <= stg_q[i-1];
               end
            end
         end
      end

      assign iob_rdata_o = stg_q[LAT-2];
   end

endmodule

// File: tb/tb_iob_mem_responder.sv
// Randomized bench for iob_mem_responder: two instances (pipelined reads without
// waits, and wait states with latency 2) checked every cycle against a transaction model.
module tb_iob_mem_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cke = 1'b1;
   logic [1:0]  avalid = '0;
   logic [11:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic [31:0] rdata0, rdata1;
   logic [1:0]  rvalid, ready;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   iob_mem_responder #(.DATA_W(32), .ADDR_W(12), .READ_LAT(3), .WAIT_STATES(0)) u_dut0 (
      .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(avalid[0]),
      .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
      .iob_rdata_o(rdata0), .iob_rvalid_o(rvalid[0]), .iob_ready_o(ready[0]));

   iob_mem_responder #(.DATA_W(32), .ADDR_W(12), .READ_LAT(2), .WAIT_STATES(2)) u_dut1 (
      .clk_i(clk), .rst_n_i(rst_n), .cke_i(cke), .iob_avalid_i(avalid[1]),
      .iob_addr_i(addr), .iob_wdata_i(wdata), .iob_wstrb_i(wstrb),
      .iob_rdata_o(rdata1), .iob_rvalid_o(rvalid[1]), .iob_ready_o(ready[1]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 3 : 2;
   endfunction

   function automatic int ws_of(input int k);
      return (k == 0) ? 0 : 2;
   endfunction

   // Model: blocked cycles left, list of pending reads (enabled edges until shown), memory.
   int          wl [2] = '{0, 0};
   int          npend [2] = '{0, 0};
   int          prem [2][8];
   logic [31:0] pdat [2][8];
   logic [31:0] last_rd [2] = '{32'h0, 32'h0};
   logic [31:0] mmem [2][1024];
   logic        acc_m;
   int          widx;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            wl[k] = 0;
            npend[k] = 0;
            last_rd[k] = '0;
         end else if (cke) begin
            acc_m = avalid[k] && (wl[k] == 0);
            if (npend[k] > 0 && prem[k][0] == 0) begin
               for (int i = 0; i < 7; i++) begin
                  prem[k][i] = prem[k][i+1];
                  pdat[k][i] = pdat[k][i+1];
               end
               npend[k]--;
            end
            for (int i = 0; i < npend[k]; i++) prem[k][i]--;
            if (acc_m) begin
               widx = int'(addr[11:2]);
               if (wstrb != 4'h0) begin
                  for (int b = 0; b < 4; b++) begin
                     if (wstrb[b]) mmem[k][widx][8*b +: 8] = wdata[8*b +: 8];
                  end
               end else begin
                  prem[k][npend[k]] = lat_of(k) - 1;
                  pdat[k][npend[k]] = mmem[k][widx];
                  npend[k]++;
               end
               wl[k] = ws_of(k);
            end else if (wl[k] > 0) begin
               wl[k]--;
            end
            if (npend[k] > 0 && prem[k][0] == 0) last_rd[k] = pdat[k][0];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check("ready0", 32'(ready[0]), 32'(rst_n && wl[0] == 0));
      check("ready1", 32'(ready[1]), 32'(rst_n && wl[1] == 0));
      check("rvalid0", 32'(rvalid[0]), 32'(npend[0] > 0 && prem[0][0] == 0));
      check("rvalid1", 32'(rvalid[1]), 32'(npend[1] > 0 && prem[1][0] == 0));
      check("rdata0", rdata0, last_rd[0]);
      check("rdata1", rdata1, last_rd[1]);
   endtask

   task automatic idle(input int n);
      avalid = '0;
      repeat (n) tick();
   endtask

   // Presents one request to both instances, holding avalid per instance until accepted.
   task automatic do_req(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                         input bit rnd_cke);
      logic [1:0] acc_now;
      addr = a;
      wdata = d;
      wstrb = s;
      avalid = 2'b11;
      for (int n = 0; n < 60 && avalid != 2'b00; n++) begin
         cke = rnd_cke ? ($urandom_range(0, 5) != 0) : 1'b1;
         for (int k = 0; k < 2; k++) acc_now[k] = avalid[k] && rst_n && cke && (wl[k] == 0);
         tick();
         avalid = avalid & ~acc_now;
      end
      if (avalid != 2'b00) begin
         check("req_timeout", 32'(avalid), 32'h0);
         avalid = '0;
      end
      cke = 1'b1;
   endtask

   function automatic logic [11:0] rnd_addr();
      logic [3:0] w;
      logic [1:0] lsb;
      w = 4'($urandom_range(0, 15));
      lsb = 2'($urandom);
      return {6'b0, w, lsb};
   endfunction

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      do_req(12'h010, 32'hDEADBEEF, 4'hF, 1'b0);
      do_req(12'h010, 32'h0, 4'h0, 1'b0);
      idle(4);
      do_req(12'h010, 32'h000000AA, 4'h1, 1'b0);
      do_req(12'h013, 32'h0, 4'h0, 1'b0);
      idle(4);

      for (int w = 0; w < 16; w++) begin
         if (w != 4) do_req(12'(w * 4), $urandom, 4'hF, 1'b0);
      end

      do_req(12'h000, 32'h0, 4'h0, 1'b0);
      do_req(12'h004, 32'h0, 4'h0, 1'b0);
      do_req(12'h008, 32'h0, 4'h0, 1'b0);
      idle(6);

      wstrb = 4'h0;
      avalid = 2'b11;
      for (int i = 0; i < 9; i++) begin
         addr = rnd_addr();
         tick();
      end
      idle(6);

      do_req(12'h008, 32'h0, 4'h0, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      idle(6);

      do_req(12'h00C, 32'h0, 4'h0, 1'b0);
      cke = 1'b0;
      repeat (4) tick();
      cke = 1'b1;
      idle(6);

      for (int i = 0; i < 250; i++) begin
         idle($urandom_range(0, 2));
         if ($urandom_range(0, 39) == 0) begin
            rst_n = 1'b0;
            repeat ($urandom_range(1, 2)) tick();
            rst_n = 1'b1;
         end
         if ($urandom_range(0, 1) == 0)
            do_req(rnd_addr(), $urandom, 4'($urandom_range(1, 15)), 1'b1);
         else
            do_req(rnd_addr(), $urandom, 4'h0, 1'b1);
      end
      idle(8);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
